// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with a run-time programmable modulus.
// Edge priority: clear, then modulus write, then load, then count.
// The modulus written on an edge is already the one used for load and
// count checks on that same edge.
module mod_n_updown_counter #(
    parameter int WIDTH       = 4,
    parameter int MOD_DEFAULT = 10
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             mod_wr,
    input  logic [WIDTH:0]   mod_value,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic             wrap,
    output logic [WIDTH:0]   modulus,
    output logic             err
);

    localparam logic [WIDTH:0]   MOD_MAX = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0]   MOD_RST = (WIDTH+1)'(MOD_DEFAULT);
    localparam logic [WIDTH:0]   ONE     = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] Q_ONE   = WIDTH'(1);

    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   lv_ext;
    logic [WIDTH:0]   m_eff;
    logic             mod_ok;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    logic             err_nxt;

    // All comparisons run at WIDTH+1 bits so M = 2^WIDTH needs no special case.
    assign q_ext  = {1'b0, q};
    assign lv_ext = {1'b0, load_value};
    assign q_bar  = ~q;
    // tc looks at the modulus register only, never at a pending mod_value.
    assign tc     = enable & ~load & (up_down ? (q_ext == modulus - ONE) : (q_ext == '0));

    // Next-state decode: effective modulus, then load, forced zero, or count.
    always_comb begin
        mod_ok   = mod_wr && (mod_value != '0) && (mod_value <= MOD_MAX);
        m_eff    = mod_ok ? mod_value : modulus;
        q_nxt    = q;
        wrap_nxt = 1'b0;
        err_nxt  = err;
        if (mod_wr && !mod_ok) begin
            err_nxt = 1'b1;
        end
        if (load) begin
            if (lv_ext < m_eff) begin
                q_nxt = load_value;
            end else begin
                q_nxt   = '0;
                err_nxt = 1'b1;
            end
        end else if (mod_ok && (q_ext >= m_eff)) begin
            // A shrinking modulus strands q out of range; pull it back to zero
            // without reporting a wrap.
            q_nxt = '0;
        end else if (enable) begin
            if (up_down) begin
                if (q_ext == m_eff - ONE) begin
                    q_nxt    = '0;
                    wrap_nxt = 1'b1;
                end else begin
                    q_nxt = q + Q_ONE;
                end
            end else begin
                if (q_ext == '0) begin
                    q_nxt    = WIDTH'(m_eff - ONE);
                    wrap_nxt = 1'b1;
                end else begin
                    q_nxt = q - Q_ONE;
                end
            end
        end
    end

    // State registers with synchronous active-high clear.
    always_ff @(posedge clock) begin
        if (clear) begin
            q       <= '0;
            modulus <= MOD_RST;
            wrap    <= 1'b0;
            err     <= 1'b0;
        end else begin
            q       <= q_nxt;
            modulus <= m_eff;
            wrap    <= wrap_nxt;
            err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Bench for mod_n_updown_counter (WIDTH=4, MOD_DEFAULT=10): directed
// scenarios followed by random stimulus, all checked against an integer
// reference model of the counter's rules.
module tb_mod_n_updown_counter;

    logic       clock;
    logic       clear;
    logic       enable;
    logic       up_down;
    logic       load;
    logic [3:0] load_value;
    logic       mod_wr;
    logic [4:0] mod_value;
    logic [3:0] q;
    logic [3:0] q_bar;
    logic       tc;
    logic       wrap;
    logic [4:0] modulus;
    logic       err;

    int total = 0;
    int bad   = 0;

    // reference model state
    int  mq, mm, mw_pulse, me;
    bit  model_valid = 0;

    mod_n_updown_counter #(.WIDTH(4), .MOD_DEFAULT(10)) dut (
        .clock(clock), .clear(clear), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value), .mod_wr(mod_wr), .mod_value(mod_value),
        .q(q), .q_bar(q_bar), .tc(tc), .wrap(wrap), .modulus(modulus), .err(err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs, advance the
    // model, clock the DUT, check registered outputs.
    task automatic step(input int c, input int en, input int ud, input int ld,
                        input int lv, input int mw, input int mv);
        int  mnew;
        bit  ok;
        clear      = c[0];
        enable     = en[0];
        up_down    = ud[0];
        load       = ld[0];
        load_value = 4'(lv);
        mod_wr     = mw[0];
        mod_value  = 5'(mv);
        #1;
        if (model_valid) begin
            chk("tc", 32'(tc), 32'((en != 0) && (ld == 0) &&
                                   ((ud != 0) ? (mq == mm - 1) : (mq == 0))));
            chk("q_bar", 32'(q_bar), 32'(15 - mq));
        end
        if (c != 0) begin
            mq = 0; mm = 10; mw_pulse = 0; me = 0;
            model_valid = 1;
        end else begin
            ok = (mw != 0) && (mv >= 1) && (mv <= 16);
            if ((mw != 0) && !ok) me = 1;
            mnew = ok ? mv : mm;
            mw_pulse = 0;
            if (ld != 0) begin
                if (lv < mnew) mq = lv;
                else begin mq = 0; me = 1; end
            end else if (ok && mq >= mnew) begin
                mq = 0;
            end else if (en != 0) begin
                if (ud != 0) begin
                    mw_pulse = (mq == mnew - 1) ? 1 : 0;
                    mq = (mq + 1) % mnew;
                end else begin
                    mw_pulse = (mq == 0) ? 1 : 0;
                    mq = (mq + mnew - 1) % mnew;
                end
            end
            mm = mnew;
        end
        @(posedge clock);
        #1;
        chk("q", 32'(q), 32'(mq));
        chk("wrap", 32'(wrap), 32'(mw_pulse));
        chk("modulus", 32'(modulus), 32'(mm));
        chk("err", 32'(err), 32'(me));
    endtask

    initial begin
        int r, mv;
        clear = 1'b0; enable = 1'b0; up_down = 1'b0; load = 1'b0;
        load_value = '0; mod_wr = 1'b0; mod_value = '0;

        // 1: clear then count up through a wrap
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0, 0, 0);
        chk("plan1_q_end", 32'(q), 32'd2);

        // 2: count down from zero through a wrap
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0, 0, 0);

        // 3: shrink modulus below q, then widen to full range, then illegal
        step(0, 0, 1, 1, 7, 0, 0);
        step(0, 1, 1, 0, 0, 1, 5);
        chk("plan3_forced_zero", 32'(q), 32'd0);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1, 16);
        for (int i = 0; i < 18; i++) step(0, 1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 1, 17);
        chk("plan3_err", 32'(err), 32'd1);

        // 4: illegal and legal loads, same-edge modulus write with load
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 12, 0, 0);
        step(0, 1, 1, 1, 6, 0, 0);
        step(0, 1, 1, 1, 3, 1, 4);
        chk("plan4_q", 32'(q), 32'd3);

        // 5: clear overrides load and mod_wr
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 5, 1, 3);

        // 6: modulus 1, then disable
        step(0, 1, 1, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);

        // random traffic
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      mv = 0;
            else if (r == 1) mv = $urandom_range(17, 31);
            else             mv = $urandom_range(1, 16);
            step(($urandom_range(0, 99) == 0) ? 1 : 0,
                 ($urandom_range(0, 3) != 0) ? 1 : 0,
                 $urandom_range(0, 1),
                 ($urandom_range(0, 11) == 0) ? 1 : 0,
                 $urandom_range(0, 15),
                 ($urandom_range(0, 15) == 0) ? 1 : 0,
                 mv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_n_updown_counter.md
Name: mod_n_updown_counter

Overview:
Parametrised modulo-N counter with a run-time programmable modulus. Counts up or down, with enable, synchronous parallel load, complement output, a terminal-count flag, a wrap pulse and a sticky error flag. It is the general-purpose successor to the fixed-modulus counter, used for cascaded dividers, timers and sequence indexing.

Parameters:
WIDTH, 4, counter width in bits; legal range 1..16.
MOD_DEFAULT, 10, modulus loaded at reset; legal range 1..2^WIDTH.

Ports:
clock  input  1  single system clock; all state changes on its rising edge.
clear  input  1  reset, synchronous, active-high.
enable  input  1  count enable.
up_down  input  1  direction: 1 = up, 0 = down.
load  input  1  synchronous parallel load strobe.
load_value  input  WIDTH  value for load.
mod_wr  input  1  modulus write strobe.
mod_value  input  WIDTH+1  new modulus; legal range 1..2^WIDTH.
q  output  WIDTH  counter value, registered.
q_bar  output  WIDTH  bitwise complement of q, combinational.
tc  output  1  terminal count flag, combinational.
wrap  output  1  one-cycle pulse, registered.
modulus  output  WIDTH+1  current modulus register, registered.
err  output  1  sticky error flag, registered.

Behaviour:
- Interface: one clock (clock). Reset is clear, synchronous and active-high.
- Reset values when clear = 1 at an edge: q = 0, modulus = MOD_DEFAULT, wrap = 0, err = 0. Clear overrides every other input in that cycle.
- Priority at each edge (clear = 0):
  - mod_wr is evaluated first and defines the modulus M used for the rest of the same edge.
  - Then load.
  - Then count.
- mod_wr handling:
  - If 1 <= mod_value <= 2^WIDTH: modulus <= mod_value.
  - Otherwise (0 or greater than 2^WIDTH): modulus is unchanged and err <= 1.
- load = 1:
  - If load_value < M: q <= load_value.
  - Otherwise: q <= 0 and err <= 1.
  - enable is ignored during a load cycle.
- Out-of-range value after a modulus change: if load = 0, mod_wr legally changes the modulus, and q >= new M, then q <= 0 in that cycle regardless of enable. No wrap pulse is generated.
- Count (enable = 1, load = 0, no forced zero):
  - Up: q <= (q == M-1) ? 0 : q+1.
  - Down: q <= (q == 0) ? M-1 : q-1.
  - M = 2^WIDTH gives natural binary roll-over. M = 1 holds q at 0 permanently.
- enable = 0 with no load or mod_wr: q holds.
- tc = enable & ~load & (up_down ? q == M-1 : q == 0), where M is the modulus register value (not a pending mod_value). With M = 1, tc = enable & ~load.
- wrap: goes to 1 for exactly one cycle after any count edge where q went from M-1 to 0 (up) or from 0 to M-1 (down). Otherwise 0.
  - Consequence: wrap at cycle n+1 equals tc at cycle n, except across a mod_wr edge.
- err: set only by the conditions above. Cleared only by clear.
- Direction change: takes effect at the same edge; no dead cycle.
- Arithmetic: unsigned; comparisons are done at WIDTH+1 bits. q never leaves the range 0..M-1 after any edge.

Test Plan (all scenarios use WIDTH=4, MOD_DEFAULT=10):
1. clear = 1 for 2 cycles, then enable = 1, up_down = 1, for 12 cycles.
   -> q = 0,1,...,9,0,1. tc = 1 only while q = 9. wrap = 1 only in the cycle q = 0 after 9. q_bar = ~q throughout (0xF at q = 0, 0x6 at q = 9).
2. From q = 0, up_down = 0, enable = 1.
   -> q = 9,8,...,0,9. tc = 1 while q = 0. wrap pulses in the cycle after each 0 -> 9 transition.
3. At q = 7, apply mod_wr with mod_value = 5.
   -> next q = 0, modulus = 5, wrap = 0. Count up then gives 0..4,0.
   Then mod_wr with mod_value = 16 -> counts 0..15,0, tc at 15.
   Then mod_wr with mod_value = 17 -> modulus stays 16, err = 1.
4. Fresh clear, then load with load_value = 12 (M = 10).
   -> q = 0, err = 1. Then load with load_value = 6 -> q = 6, err stays 1.
   Same-edge mod_wr with mod_value = 4 plus load with load_value = 3 -> modulus = 4, q = 3.
5. During counting, assert clear together with load (load_value = 5) and mod_wr (mod_value = 3).
   -> q = 0, modulus = 10, err = 0, wrap = 0 at the next edge.
6. Set modulus = 1 and enable = 1.
   -> q stays 0, tc = 1 every cycle, wrap = 1 every cycle after the first.
   Set enable = 0 -> tc = 0, wrap = 0 next cycle, q holds.
